// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state type shared by the AXI-Lite register slave
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_WAIT, WR_RESP} axi_slv_state_t;
endpackage

// File: rtl/axi_lite_wr_capture.sv
// axi_lite_wr_capture: independent AW and W holding registers; a write is pending once both are full
module axi_lite_wr_capture #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            block_i,
    input  logic            clr_i,
    input  logic [AW-1:0]   aw_addr_i,
    input  logic            aw_valid_i,
    output logic            aw_ready_o,
    input  logic [DW-1:0]   w_data_i,
    input  logic [DW/8-1:0] w_strb_i,
    input  logic            w_valid_i,
    output logic            w_ready_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   data_o,
    output logic [DW/8-1:0] strb_o,
    output logic            pending_o
);
    logic aw_full, w_full;
    assign aw_ready_o = !rst_i && !aw_full && !block_i;
    assign w_ready_o  = !rst_i && !w_full && !block_i;
    assign pending_o  = aw_full && w_full;
    // fill each buffer on its own handshake; empty both when the write response is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            strb_o  <= '0;
        end else if (clr_i) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_valid_i && aw_ready_o) begin
                aw_full <= 1'b1;
                addr_o  <= aw_addr_i;
            end
            if (w_valid_i && w_ready_o) begin
                w_full <= 1'b1;
                data_o <= w_data_i;
                strb_o <= w_strb_i;
            end
        end
    end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite slave bridging to a req/gnt/rvalid register bus with decode, timeout and RR arbitration
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                AXI_AW      = 16,
    parameter int                AXI_DW      = 32,
    parameter logic [AXI_AW-1:0] ADDR_LIMIT  = 'h1000,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AXI_AW-1:0]   aw_addr_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [AXI_DW-1:0]   w_data_i,
    input  logic [AXI_DW/8-1:0] w_strb_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    output logic [1:0]          b_resp_o,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    input  logic [AXI_AW-1:0]   ar_addr_i,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    output logic [AXI_DW-1:0]   r_data_o,
    output logic [1:0]          r_resp_o,
    output logic                r_valid_o,
    input  logic                r_ready_i,
    output logic                reg_req_o,
    output logic                reg_we_o,
    output logic [AXI_AW-1:0]   reg_addr_o,
    output logic [AXI_DW-1:0]   reg_wdata_o,
    output logic [AXI_DW/8-1:0] reg_be_o,
    input  logic                reg_gnt_i,
    input  logic                reg_rvalid_i,
    input  logic [AXI_DW-1:0]   reg_rdata_i,
    input  logic                reg_err_i
);
    axi_slv_state_t      state_q, state_d;
    logic [15:0]         cnt_q;
    logic                rd_first_q;
    logic [AXI_DW-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic [AXI_AW-1:0]   cap_addr;
    logic [AXI_DW-1:0]   cap_data;
    logic [AXI_DW/8-1:0] cap_strb;
    logic                wr_pend, wr_state, in_req, in_wait, expire, wr_win, ar_hs, wr_go, rd_dec, wr_dec;

    assign wr_state   = state_q == WR_REQ || state_q == WR_WAIT || state_q == WR_RESP;
    assign in_req     = state_q == RD_REQ || state_q == WR_REQ;
    assign in_wait    = state_q == RD_WAIT || state_q == WR_WAIT;
    assign expire     = (in_req || in_wait) && cnt_q == 16'(TIMEOUT_CYC - 1);
    assign wr_win     = wr_pend && (!ar_valid_i || !rd_first_q);
    assign ar_ready_o = !rst_i && state_q == IDLE && !wr_win;
    assign ar_hs      = ar_valid_i && ar_ready_o;
    assign wr_go      = !rst_i && state_q == IDLE && wr_win;
    assign rd_dec     = ar_addr_i >= ADDR_LIMIT;
    assign wr_dec     = cap_addr >= ADDR_LIMIT;
    assign reg_req_o  = in_req;
    assign r_valid_o  = state_q == RD_RESP;
    assign b_valid_o  = state_q == WR_RESP;
    assign r_data_o   = rdata_q;
    assign r_resp_o   = resp_q;
    assign b_resp_o   = resp_q;

    axi_lite_wr_capture #(.AW(AXI_AW), .DW(AXI_DW)) u_cap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .block_i    (wr_state),
        .clr_i      (state_q == WR_RESP && b_ready_i),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .addr_o     (cap_addr),
        .data_o     (cap_data),
        .strb_o     (cap_strb),
        .pending_o  (wr_pend)
    );

    // state register
    always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

    // next state; timeout takes priority over gnt and rvalid
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ar_hs ? (rd_dec ? RD_RESP : RD_REQ) : wr_go ? (wr_dec ? WR_RESP : WR_REQ) : IDLE;
            RD_REQ:  state_d = expire ? RD_RESP : reg_gnt_i ? RD_WAIT : RD_REQ;
            RD_WAIT: state_d = (expire || reg_rvalid_i) ? RD_RESP : RD_WAIT;
            RD_RESP: state_d = r_ready_i ? IDLE : RD_RESP;
            WR_REQ:  state_d = expire ? WR_RESP : reg_gnt_i ? WR_WAIT : WR_REQ;
            WR_WAIT: state_d = (expire || reg_rvalid_i) ? WR_RESP : WR_WAIT;
            WR_RESP: state_d = b_ready_i ? IDLE : WR_RESP;
            default: state_d = IDLE;
        endcase
    end

    // latch the transaction at acceptance, track timeout, capture completion status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rd_first_q  <= 1'b1;
            reg_addr_o  <= '0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            reg_be_o    <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            cnt_q <= (in_req || in_wait) ? cnt_q + 16'd1 : 16'd0;
            if (ar_hs) begin
                rd_first_q  <= !rd_first_q;
                reg_addr_o  <= ar_addr_i;
                reg_we_o    <= 1'b0;
                reg_wdata_o <= '0;
                reg_be_o    <= '0;
                rdata_q     <= '0;
                resp_q      <= rd_dec ? RESP_DECERR : RESP_OKAY;
            end else if (wr_go) begin
                rd_first_q  <= !rd_first_q;
                reg_addr_o  <= cap_addr;
                reg_we_o    <= 1'b1;
                reg_wdata_o <= cap_data;
                reg_be_o    <= cap_strb;
                resp_q      <= wr_dec ? RESP_DECERR : RESP_OKAY;
            end
            if (expire) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= '0;
            end else if (in_wait && reg_rvalid_i) begin
                resp_q <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
                if (state_q == RD_WAIT) rdata_q <= reg_rdata_i;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: scoreboard bench with directed vectors for the AXI-Lite register slave
module tb_axi_lite_reg_slave;
    localparam int TMO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] aw_addr_i = '0, ar_addr_i = '0, reg_addr_o;
    logic        aw_valid_i = 0, aw_ready_o, w_valid_i = 0, w_ready_o, b_valid_o, b_ready_i = 1;
    logic        ar_valid_i = 0, ar_ready_o, r_valid_o, r_ready_i = 1;
    logic [31:0] w_data_i = '0, r_data_o, reg_wdata_o, reg_rdata_i = '0;
    logic [3:0]  w_strb_i = '0, reg_be_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic        reg_req_o, reg_we_o, reg_gnt_i = 0, reg_rvalid_i = 0, reg_err_i = 0;

    typedef struct {logic [31:0] data; logic [1:0] resp; bit chk_data;} rsp_t;
    typedef struct {logic we; logic [15:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] rdata; logic err;} txn_t;
    rsp_t        rq[$];
    logic [1:0]  bq[$];
    txn_t        gq[$];
    int          checks = 0, failures = 0, req_seen = 0;
    bit          gnt_en = 1, rsp_en = 1, inj = 0, fire = 0;
    logic [31:0] pend_rdata = '0;
    logic        pend_err = 0;

    axi_lite_reg_slave #(.AXI_AW(16), .AXI_DW(32), .ADDR_LIMIT(16'h1000), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_be_o(reg_be_o), .reg_gnt_i(reg_gnt_i), .reg_rvalid_i(reg_rvalid_i), .reg_rdata_i(reg_rdata_i),
        .reg_err_i(reg_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // peripheral: grants in the request cycle, answers one cycle later with the expected txn's data
    initial forever begin
        @(negedge clk);
        reg_rvalid_i = (fire && rsp_en) || inj;
        reg_rdata_i  = pend_rdata;
        reg_err_i    = pend_err;
        inj          = 0;
        fire         = 0;
        reg_gnt_i    = !rst && reg_req_o && gnt_en;
        if (!rst && reg_req_o) req_seen++;
        if (reg_gnt_i) begin
            fire = 1;
            if (gq.size() == 0) check("reg_unexpected", 1, 0);
            else begin
                txn_t t;
                t = gq.pop_front();
                check("reg_we", reg_we_o, t.we);
                check("reg_addr", reg_addr_o, t.addr);
                check("reg_be", reg_be_o, t.be);
                check("reg_wdata", reg_wdata_o, t.wdata);
                pend_rdata = t.rdata;
                pend_err   = t.err;
            end
        end
    end

    // response monitor: pop and compare on every R/B handshake
    initial forever begin
        @(negedge clk);
        if (!rst && r_valid_o && r_ready_i) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else begin
                rsp_t e;
                e = rq.pop_front();
                check("r_resp", r_resp_o, e.resp);
                if (e.chk_data) check("r_data", r_data_o, e.data);
            end
        end
        if (!rst && b_valid_o && b_ready_i) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else check("b_resp", b_resp_o, bq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a);
        ar_addr_i = a;
        ar_valid_i = 1;
        #1;
        for (int i = 0; i < 50 && !ar_ready_o; i++) tick;
        if (!ar_ready_o) check("ar_accept", 0, 1);
        tick;
        ar_valid_i = 0;
    endtask

    task automatic do_aw(input logic [15:0] a);
        aw_addr_i = a;
        aw_valid_i = 1;
        #1;
        for (int i = 0; i < 50 && !aw_ready_o; i++) tick;
        if (!aw_ready_o) check("aw_accept", 0, 1);
        tick;
        aw_valid_i = 0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        w_data_i = d;
        w_strb_i = s;
        w_valid_i = 1;
        #1;
        for (int i = 0; i < 50 && !w_ready_o; i++) tick;
        if (!w_ready_o) check("w_accept", 0, 1);
        tick;
        w_valid_i = 0;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!r_valid_o && n < 100) begin tick; n++; end
        if (!r_valid_o) check("r_valid_wait", 0, 1);
    endtask

    task automatic wait_bv(output int n);
        n = 0;
        while (!b_valid_o && n < 100) begin tick; n++; end
        if (!b_valid_o) check("b_valid_wait", 0, 1);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 200 && (rq.size() + bq.size()) != 0; i++) tick;
        check("drain", rq.size() + bq.size(), 0);
    endtask

    task automatic push_rd(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
        gq.push_back('{we: 0, addr: a, be: 4'h0, wdata: 32'h0, rdata: d, err: resp == 2'b10});
        rq.push_back('{data: d, resp: resp, chk_data: 1});
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic err);
        gq.push_back('{we: 1, addr: a, be: s, wdata: d, rdata: 32'h0, err: err});
        bq.push_back(err ? 2'b10 : 2'b00);
    endtask

    initial begin
        int n, seen;
        // reset state
        repeat (3) tick;
        check("rst_ctrl", {aw_ready_o, w_ready_o, ar_ready_o, r_valid_o, b_valid_o, reg_req_o, reg_we_o}, 0);
        check("rst_data", {r_data_o, r_resp_o, b_resp_o, reg_addr_o, reg_wdata_o, reg_be_o}, 0);
        rst = 0;
        #1;
        check("idle_ready", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);

        // plain read: r_valid three cycles after the AR handshake
        push_rd(16'h0010, 32'hDEADBEEF, 2'b00);
        do_read(16'h0010);
        wait_rv(n);
        check("rd_latency", n + 1, 3);
        wait_idle;

        // W two cycles before AW, b_ready held low for five cycles
        push_wr(16'h0020, 32'h12345678, 4'b0011, 0);
        b_ready_i = 0;
        do_w(32'h12345678, 4'b0011);
        tick;
        tick;
        do_aw(16'h0020);
        wait_bv(n);
        for (int i = 0; i < 5; i++) begin
            check("b_hold_valid", b_valid_o, 1);
            check("b_hold_resp", b_resp_o, 2'b00);
            tick;
        end
        b_ready_i = 1;
        wait_idle;

        // decode errors never reach the register bus
        seen = req_seen;
        rq.push_back('{data: 32'h0, resp: 2'b11, chk_data: 0});
        do_read(16'h1000);
        wait_idle;
        bq.push_back(2'b11);
        do_w(32'hFFFFFFFF, 4'hF);
        do_aw(16'h2000);
        wait_idle;
        check("decerr_no_req", req_seen - seen, 0);

        // timeout: granted but never answered; late rvalid ignored
        rsp_en = 0;
        r_ready_i = 0;
        rq.push_back('{data: 32'h0, resp: 2'b10, chk_data: 1});
        gq.push_back('{we: 0, addr: 16'h0030, be: 4'h0, wdata: 32'h0, rdata: 32'h0, err: 0});
        do_read(16'h0030);
        wait_rv(n);
        check("tmo_latency", n, TMO);
        check("tmo_req_low", reg_req_o, 0);
        inj = 1;
        tick;
        tick;
        check("tmo_late_valid", r_valid_o, 1);
        check("tmo_late_resp", r_resp_o, 2'b10);
        check("tmo_late_data", r_data_o, 0);
        r_ready_i = 1;
        wait_idle;
        rsp_en = 1;
        inj = 1;
        tick;
        tick;
        check("late_idle_rvalid", r_valid_o, 0);
        push_rd(16'h0034, 32'hAAAA5555, 2'b00);
        do_read(16'h0034);
        wait_idle;

        // reset during RD_WAIT, then a clean read
        rsp_en = 0;
        gq.push_back('{we: 0, addr: 16'h0090, be: 4'h0, wdata: 32'h0, rdata: 32'h0, err: 0});
        do_read(16'h0090);
        tick;
        rst = 1;
        tick;
        check("midrst_ctrl", {aw_ready_o, w_ready_o, ar_ready_o, r_valid_o, b_valid_o, reg_req_o, reg_we_o}, 0);
        check("midrst_data", {r_data_o, r_resp_o, b_resp_o, reg_addr_o, reg_wdata_o, reg_be_o}, 0);
        rst = 0;
        rsp_en = 1;
        #1;
        check("midrst_idle", ar_ready_o, 1);
        push_rd(16'h00A0, 32'h0BADF00D, 2'b00);
        do_read(16'h00A0);
        wait_idle;

        // arbitration after reset: read first, then the write
        rst = 1;
        tick;
        tick;
        rst = 0;
        push_rd(16'h0070, 32'h11112222, 2'b00);
        push_wr(16'h0080, 32'h33334444, 4'hF, 0);
        ar_addr_i = 16'h0070; ar_valid_i = 1;
        aw_addr_i = 16'h0080; aw_valid_i = 1;
        w_data_i = 32'h33334444; w_strb_i = 4'hF; w_valid_i = 1;
        #1;
        check("arb_all_ready", {ar_ready_o, aw_ready_o, w_ready_o}, 3'b111);
        tick;
        ar_valid_i = 0; aw_valid_i = 0; w_valid_i = 0;
        wait_idle;

        // lone read flips the flag to write-first; contested IDLE then serves the write (with error)
        push_rd(16'h0040, 32'h55556666, 2'b00);
        r_ready_i = 0;
        do_read(16'h0040);
        wait_rv(n);
        push_wr(16'h0050, 32'hCAFEF00D, 4'hF, 1);
        push_rd(16'h0060, 32'h77778888, 2'b00);
        aw_addr_i = 16'h0050; aw_valid_i = 1;
        w_data_i = 32'hCAFEF00D; w_strb_i = 4'hF; w_valid_i = 1;
        ar_addr_i = 16'h0060; ar_valid_i = 1;
        #1;
        tick;
        aw_valid_i = 0; w_valid_i = 0;
        check("ar_busy", ar_ready_o, 0);
        r_ready_i = 1;
        tick;
        check("ar_blocked_by_write", ar_ready_o, 0);
        for (int i = 0; i < 50 && !ar_ready_o; i++) tick;
        check("ar_after_write", ar_ready_o, 1);
        tick;
        ar_valid_i = 0;
        wait_idle;
        check("reg_txn_drain", gq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
